dmem_arbiter: RTL

//   Shares the single data-memory SRAM port between two requesters:
//   - CPU memory stage (port cpu_*).
//   - External load/debug master (port ext_*).

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU vs external master, round-robin with
// an external burst lock and in-order 1-cycle read-data return.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    LAST_CPU,
    LAST_EXT,
    EXT_LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic              pend_cpu_q, pend_cpu_d;
  logic              pend_ext_q, pend_ext_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] ext_hold_q, ext_hold_d;

  // Leaving EXT_LOCKED arbitrates exactly like LAST_EXT.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (state_q == EXT_LOCKED && ext_lock && ext_req) begin
        ext_gnt = 1'b1;
      end else if (cpu_req && ext_req) begin
        if (state_q == LAST_CPU) begin
          ext_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (cpu_gnt) begin
      state_d = LAST_CPU;
    end else if (ext_gnt) begin
      state_d = ext_lock ? EXT_LOCKED : LAST_EXT;
    end else if (state_q == EXT_LOCKED) begin
      state_d = LAST_EXT;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_addr  = ext_gnt ? ext_addr : cpu_addr;
  assign mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;
  assign mem_wen   = (cpu_gnt & cpu_wen) | (ext_gnt & ext_wen);
  assign mem_ren   = (cpu_gnt & ~cpu_wen) | (ext_gnt & ~ext_wen);

  assign pend_cpu_d = cpu_gnt & ~cpu_wen;
  assign pend_ext_d = ext_gnt & ~ext_wen;

  assign cpu_rvalid = pend_cpu_q & ~rst;
  assign ext_rvalid = pend_ext_q & ~rst;

  assign cpu_hold_d = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign ext_hold_d = ext_rvalid ? mem_rdata : ext_hold_q;

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign ext_rdata = ext_rvalid ? mem_rdata : ext_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LAST_EXT;
      pend_cpu_q <= 1'b0;
      pend_ext_q <= 1'b0;
      cpu_hold_q <= '0;
      ext_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_cpu_q <= pend_cpu_d;
      pend_ext_q <= pend_ext_d;
      cpu_hold_q <= cpu_hold_d;
      ext_hold_q <= ext_hold_d;
    end
  end

endmodule
